regfile_dump_ctrl: RTL and testbench

- Debug-side controller that owns read port 1 of the MIPS register file.
- In normal operation it passes the decode stage's read address and valid straight through to the register file.
- On a dump request it stalls the pipeline, reads registers 0..N_REGS-1 in sequence, and streams each word LSB-byte-first over a byte-wide transmitter handshake (UART TX).
- It then releases the stall and pulses done.

---
 rtl/regfile_dump_ctrl_if.sv | 35 +++
 rtl/regfile_dump_ctrl.sv | 149 ++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl_if
// Brief    : Decode read-port, register-file port 1 and byte-TX handshake
//            bundle for the register-file dump controller.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_dump_ctrl_if #(
   parameter int N_BITS     = 32,
   parameter int N_BITS_REG = 5
);
   logic                  i_dump_req;
   logic [N_BITS_REG-1:0] i_pipe_read_reg;
   logic                  i_pipe_valid;
   logic [N_BITS_REG-1:0] o_read_reg;
   logic                  o_rf_valid;
   logic [N_BITS-1:0]     i_read_data;
   logic                  o_stall;
   logic [7:0]            o_tx_data;
   logic                  o_tx_start;
   logic                  i_tx_done;
   logic                  o_busy;
   logic                  o_done;

   modport slave (
      input  i_dump_req, i_pipe_read_reg, i_pipe_valid, i_read_data, i_tx_done,
      output o_read_reg, o_rf_valid, o_stall, o_tx_data, o_tx_start, o_busy, o_done
   );

   modport master (
      output i_dump_req, i_pipe_read_reg, i_pipe_valid, i_read_data, i_tx_done,
      input  o_read_reg, o_rf_valid, o_stall, o_tx_data, o_tx_start, o_busy, o_done
   );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl
// Brief    : Owns register-file read port 1; on request stalls the pipe and
//            streams every register LSB-byte-first over a byte TX handshake.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl #(
   parameter int N_BITS     = 32,
   parameter int N_BITS_REG = 5,
   parameter int N_REGS     = 32
) (
   input  wire logic          i_clk,
   input  wire logic          i_reset,
   regfile_dump_ctrl_if.slave bus
);

   localparam int c_n_bytes = N_BITS / 8;
   localparam int c_ridx_w  = $clog2(N_REGS) + 1;
   localparam int c_bidx_w  = $clog2(c_n_bytes) + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_SEND    = 3'd3,
      S_WAIT_TX = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                r_state;
   logic [c_ridx_w-1:0]   r_reg_idx;
   logic [c_bidx_w-1:0]   r_byte_idx;
   logic [N_BITS-1:0]     r_word;
   logic [7:0]            r_tx_data;
   logic                  r_tx_start;
   logic                  r_stall;
   logic                  r_busy;
   logic                  r_done;

   logic [N_BITS_REG-1:0] w_read_reg;
   logic                  w_rf_valid;
   logic [c_bidx_w-1:0]   w_next_bidx;
   logic [7:0]            w_next_byte;
   logic                  w_last_byte;
   logic                  w_last_reg;

   // Read port belongs to the pipeline only while idle; outside ISSUE the
   // enable stays low so the register file output holds the captured word.
   always_comb begin
      w_read_reg = N_BITS_REG'(r_reg_idx);
      w_rf_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_read_reg = bus.i_pipe_read_reg;
            w_rf_valid = bus.i_pipe_valid;
         end
         S_ISSUE: w_rf_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_next_bidx = r_byte_idx + c_bidx_w'(1);
      w_next_byte = 8'h00;
      for (int b = 0; b < c_n_bytes; b++) begin
         if (w_next_bidx == c_bidx_w'(b)) w_next_byte = r_word[8*b +: 8];
      end
   end

   assign w_last_byte = (r_byte_idx == c_bidx_w'(c_n_bytes - 1));
   assign w_last_reg  = (r_reg_idx == c_ridx_w'(N_REGS - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_reg_idx  <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_stall    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_dump_req) begin
                  r_reg_idx  <= '0;
                  r_byte_idx <= '0;
                  r_stall    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            // Byte 0 is taken straight from the read data so the strobe
            // lands in the cycle the word buffer is loaded.
            S_WAIT: begin
               r_word     <= bus.i_read_data;
               r_tx_data  <= bus.i_read_data[7:0];
               r_tx_start <= 1'b1;
               r_state    <= S_SEND;
            end
            S_SEND: r_state <= S_WAIT_TX;
            S_WAIT_TX: begin
               if (bus.i_tx_done) begin
                  if (!w_last_byte) begin
                     r_byte_idx <= w_next_bidx;
                     r_tx_data  <= w_next_byte;
                     r_tx_start <= 1'b1;
                     r_state    <= S_SEND;
                  end else if (!w_last_reg) begin
                     r_byte_idx <= '0;
                     r_reg_idx  <= r_reg_idx + c_ridx_w'(1);
                     r_state    <= S_ISSUE;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_reg_idx <= '0;
               r_stall   <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_stall <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_read_reg = w_read_reg;
   assign bus.o_rf_valid = w_rf_valid;
   assign bus.o_stall    = r_stall;
   assign bus.o_tx_data  = r_tx_data;
   assign bus.o_tx_start = r_tx_start;
   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_ctrl
// Brief    : Directed bench with register-file and byte-TX models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;
   localparam int N_BITS     = 32;
   localparam int N_BITS_REG = 5;
   localparam int N_REGS     = 32;
   localparam int N_TX_BYTES = N_REGS * N_BITS / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_dump_ctrl_if #(.N_BITS(N_BITS), .N_BITS_REG(N_BITS_REG)) bus ();

   regfile_dump_ctrl #(
      .N_BITS    (N_BITS),
      .N_BITS_REG(N_BITS_REG),
      .N_REGS    (N_REGS)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus.slave)
   );

   logic [N_BITS-1:0] regs [N_REGS];
   logic [N_BITS-1:0] rd_q;
   always @(posedge clk) if (bus.o_rf_valid) rd_q <= regs[bus.o_read_reg];
   assign bus.i_read_data = rd_q;

   logic model_done, spur_done;
   assign bus.i_tx_done = model_done | spur_done;

   int         tx_dly, tx_cnt, done_cnt;
   bit         spur_en, spur_pend;
   logic [7:0] q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   // Byte monitor, spurious-done injector (lands in WAIT after each ISSUE)
   // and TX model returning done tx_dly cycles after each strobe.
   always @(negedge clk) begin
      if (bus.o_tx_start) q.push_back(bus.o_tx_data);
      if (bus.o_done) done_cnt++;
      spur_done = 1'b0;
      if (spur_pend) begin
         spur_done = 1'b1;
         spur_pend = 1'b0;
      end
      if (spur_en && bus.o_stall && bus.o_rf_valid) spur_pend = 1'b1;
      model_done = 1'b0;
      if (rst) tx_cnt = 0;
      else begin
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) model_done = 1'b1;
         end
         if (bus.o_tx_start) tx_cnt = tx_dly;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_word(input int r, input bit wr20);
      return (wr20 && r == 20) ? 32'h12345678 : 32'hA0B0C000 + r;
   endfunction

   task automatic check_bytes(input bit wr20);
      logic [31:0] w;
      logic [7:0]  g;
      chk("byte_count", q.size(), N_TX_BYTES);
      for (int i = 0; i < N_TX_BYTES; i++) begin
         w = exp_word(i / 4, wr20);
         g = (i < q.size()) ? q[i] : 8'hEE;
         chk($sformatf("byte%0d", i), {24'h0, g}, {24'h0, w[8*(i%4) +: 8]});
      end
   endtask

   task automatic run_dump(input int dly, input bit spur, input bit mid_req, input bit wr20);
      int cyc;
      bit did;
      q.delete();
      done_cnt = 0;
      tx_dly   = dly;
      spur_en  = spur;
      bus.i_dump_req = 1'b1;
      step();
      bus.i_dump_req = 1'b0;
      chk("stall_after_req", bus.o_stall, 1);
      chk("busy_after_req", bus.o_busy, 1);
      cyc = 0;
      did = 1'b0;
      while (done_cnt == 0 && cyc < 20000) begin
         if ((mid_req || wr20) && !did && q.size() == 41) begin
            if (mid_req) bus.i_dump_req = 1'b1;
            if (wr20) regs[20] = 32'h12345678;
            did = 1'b1;
            step();
            bus.i_dump_req = 1'b0;
         end else begin
            step();
         end
         cyc++;
      end
      chk("done_in_time", {31'h0, cyc < 20000}, 1);
      chk("done_pulse", bus.o_done, 1);
      step();
      chk("stall_after_done", bus.o_stall, 0);
      chk("busy_after_done", bus.o_busy, 0);
      chk("done_one_cycle", bus.o_done, 0);
      repeat (5) step();
      chk("done_count", done_cnt, 1);
      check_bytes(wr20);
      spur_en = 1'b0;
      regs[20] = 32'hA0B0C000 + 20;
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      bus.i_dump_req      = 1'b0;
      bus.i_pipe_read_reg = '0;
      bus.i_pipe_valid    = 1'b0;
      model_done = 1'b0;
      spur_done  = 1'b0;
      spur_pend  = 1'b0;
      spur_en    = 1'b0;
      tx_dly     = 3;
      tx_cnt     = 0;
      done_cnt   = 0;
      rd_q       = '0;
      for (int i = 0; i < N_REGS; i++) regs[i] = 32'hA0B0C000 + i;
      repeat (3) step();
      chk("rst_stall", bus.o_stall, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_tx_start", bus.o_tx_start, 0);
      chk("rst_tx_data", bus.o_tx_data, 0);
      rst = 1'b0;

      // Passthrough in IDLE
      bus.i_pipe_read_reg = 5'd5;
      bus.i_pipe_valid    = 1'b1;
      #1;
      chk("pt_read_reg", bus.o_read_reg, 5);
      chk("pt_rf_valid", bus.o_rf_valid, 1);
      chk("pt_stall", bus.o_stall, 0);
      bus.i_pipe_read_reg = 5'd9;
      bus.i_pipe_valid    = 1'b0;
      #1;
      chk("pt_read_reg2", bus.o_read_reg, 9);
      chk("pt_rf_valid2", bus.o_rf_valid, 0);
      repeat (4) step();
      chk("pt_no_tx", q.size(), 0);

      // Pipeline keeps requesting reg 5 during dumps; must be ignored
      bus.i_pipe_read_reg = 5'd5;
      bus.i_pipe_valid    = 1'b1;

      run_dump(3, 1'b0, 1'b0, 1'b0);
      run_dump(50, 1'b1, 1'b0, 1'b0);

      // Abort during WAIT_TX of register 7, byte 2
      q.delete();
      tx_dly = 3;
      bus.i_dump_req = 1'b1;
      step();
      bus.i_dump_req = 1'b0;
      cyc = 0;
      while (q.size() < 31 && cyc < 2000) begin
         step();
         cyc++;
      end
      chk("abort_reached", {31'h0, cyc < 2000}, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_stall", bus.o_stall, 0);
      chk("abort_busy", bus.o_busy, 0);
      chk("abort_done", bus.o_done, 0);
      chk("abort_tx_start", bus.o_tx_start, 0);
      chk("abort_tx_data", bus.o_tx_data, 0);
      chk("abort_passthru", bus.o_read_reg, 5);
      repeat (10) step();
      chk("abort_no_more_tx", q.size(), 31);
      run_dump(3, 1'b0, 1'b0, 1'b0);

      // Request while busy plus write to reg 20 ahead of its ISSUE
      run_dump(3, 1'b0, 1'b1, 1'b1);
      repeat (10) step();
      chk("no_restart", bus.o_busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
